// File: rtl/mux8_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mux8_rr_arbiter_if                                              |
// | Brief    : Request and output handshake bundle for mux8_rr_arbiter         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface mux8_rr_arbiter_if #(
   parameter int WIDTH = 8
);
   logic [7:0]         in_valid;
   logic [8*WIDTH-1:0] in_data;
   logic [7:0]         in_last;
   logic [7:0]         in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [2:0]         out_sel;
   logic               out_ready;

   // Producer/consumer side of the arbiter.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   // Arbiter side.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface
`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mux8_rr_arbiter (plus generic mux8 gate)                        |
// | Brief    : 8-way round-robin arbiter feeding a one-entry output register.  |
// |            Define MUX8_ARB_LOCK_EN to enable packet lock on in_last.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module mux8 #(
   parameter int WIDTH = 8
) (
   input  wire logic [WIDTH-1:0] d0,
   input  wire logic [WIDTH-1:0] d1,
   input  wire logic [WIDTH-1:0] d2,
   input  wire logic [WIDTH-1:0] d3,
   input  wire logic [WIDTH-1:0] d4,
   input  wire logic [WIDTH-1:0] d5,
   input  wire logic [WIDTH-1:0] d6,
   input  wire logic [WIDTH-1:0] d7,
   input  wire logic [2:0]       s,
   output logic      [WIDTH-1:0] y
);
   always_comb begin
      y = d0;
      case (s)
         3'd1:    y = d1;
         3'd2:    y = d2;
         3'd3:    y = d3;
         3'd4:    y = d4;
         3'd5:    y = d5;
         3'd6:    y = d6;
         3'd7:    y = d7;
         default: y = d0;
      endcase
   end
endmodule

module mux8_rr_arbiter #(
   parameter int WIDTH = 8
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   mux8_rr_arbiter_if.slave bus
);
   localparam int c_NREQ = 8;

   logic [2:0]       r_ptr;
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [2:0]       r_sel;

   logic [7:0]       w_req;
   logic [2:0]       w_grant;
   logic             w_any;
   logic             w_can_load;
   logic             w_xfer;
   logic             w_ptr_upd;
   logic [WIDTH-1:0] w_mux_y;
   logic [WIDTH-1:0] w_slice [c_NREQ];

   for (genvar gi = 0; gi < c_NREQ; gi++) begin : g_slice
      assign w_slice[gi] = bus.in_data[gi*WIDTH +: WIDTH];
   end

   // Rotating priority search starting at r_ptr; index arithmetic wraps in 3 bits.
   always_comb begin
      w_any   = 1'b0;
      w_grant = r_ptr;
      for (int k = 0; k < c_NREQ; k++) begin
         if (!w_any && w_req[r_ptr + 3'(k)]) begin
            w_any   = 1'b1;
            w_grant = r_ptr + 3'(k);
         end
      end
   end

   assign w_can_load = !r_valid || bus.out_ready;
   assign w_xfer     = rst_n && w_can_load && w_any;

   always_comb begin
      bus.in_ready = '0;
      if (w_xfer) begin
         bus.in_ready[w_grant] = 1'b1;
      end
   end

   mux8 #(
      .WIDTH (WIDTH)
   ) u_mux (
      .d0 (w_slice[0]),
      .d1 (w_slice[1]),
      .d2 (w_slice[2]),
      .d3 (w_slice[3]),
      .d4 (w_slice[4]),
      .d5 (w_slice[5]),
      .d6 (w_slice[6]),
      .d7 (w_slice[7]),
      .s  (w_grant),
      .y  (w_mux_y)
   );

`ifdef MUX8_ARB_LOCK_EN
   localparam logic [0:0] c_ST_IDLE   = 1'b0;
   localparam logic [0:0] c_ST_LOCKED = 1'b1;

   logic [0:0] r_state;
   logic [0:0] w_state_nxt;
   logic [2:0] r_owner;
   logic [2:0] w_owner_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
         r_owner <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      case (r_state)
         c_ST_IDLE: begin
            if (w_xfer && !bus.in_last[w_grant]) begin
               w_state_nxt = c_ST_LOCKED;
               w_owner_nxt = w_grant;
            end
         end
         c_ST_LOCKED: begin
            if (w_xfer && bus.in_last[r_owner]) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   // While locked only the owner is eligible, even if others are valid.
   always_comb begin
      w_req = bus.in_valid;
      if (r_state == c_ST_LOCKED) begin
         w_req = bus.in_valid & (8'b1 << r_owner);
      end
   end

   // When locked the grant is the owner, so both states rotate only on a last beat.
   assign w_ptr_upd = w_xfer && bus.in_last[w_grant];
`else
   logic w_unused_last;

   assign w_req         = bus.in_valid;
   assign w_ptr_upd     = w_xfer;
   assign w_unused_last = ^bus.in_last;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= 3'd0;
         r_ptr   <= 3'd0;
      end else begin
         if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_mux_y;
            r_sel   <= w_grant;
         end else if (bus.out_ready) begin
            r_valid <= 1'b0;
         end
         if (w_ptr_upd) begin
            r_ptr <= w_grant + 3'd1;
         end
      end
   end

   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_sel   = r_sel;
endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mux8_rr_arbiter                                              |
// | Brief    : Scoreboard bench for mux8_rr_arbiter (lock build aware)         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mux8_rr_arbiter;
   localparam int WIDTH = 8;

   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mux8_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

   mux8_rr_arbiter #(
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   beat_t exp_q[$];
   beat_t mon_e;

   // Accepted beats are consumed at the next rising edge; check them here.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: got sel=%0d data=%h, required no beat",
                     bus.out_sel, bus.out_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.out_sel !== mon_e.sel || bus.out_data !== mon_e.data) begin
               n_fail++;
               $display("FAIL beat: got sel=%0d data=%h, required sel=%0d data=%h",
                        bus.out_sel, bus.out_data, mon_e.sel, mon_e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_beat(input logic [2:0] s, input logic [7:0] d);
      beat_t b;
      b.sel  = s;
      b.data = d;
      exp_q.push_back(b);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_default_data();
      for (int i = 0; i < 8; i++) begin
         bus.in_data[i*8 +: 8] = 8'(8'h10 + i);
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 8'h00;
      bus.in_last   = 8'h00;
      bus.out_ready = 1'b1;
      set_default_data();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 30) begin
         step();
         k++;
      end
      step();
      #1;
      n_tests++;
      if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drain: got pending=%0d out_valid=%b, required pending=0 out_valid=0",
                  name, exp_q.size(), bus.out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 8'hFF;
      bus.in_last   = 8'h00;
      bus.out_ready = 1'b1;
      set_default_data();
      exp_q.delete();
      @(posedge clk);
      #3;
      n_tests++;
      if (bus.in_ready !== 8'h00 || bus.out_valid !== 1'b0 || bus.out_sel !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state: got in_ready=%h out_valid=%b out_sel=%0d, required 00/0/0",
                  bus.in_ready, bus.out_valid, bus.out_sel);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      n_tests++;
      if (bus.in_ready !== 8'h01) begin
         n_fail++;
         $display("FAIL reset_first_grant: got in_ready=%h, required 01", bus.in_ready);
      end
      push_beat(3'd0, 8'h10);
      step();
      bus.in_valid = 8'h00;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_first_out: got out_valid=%b out_sel=%0d, required 1/0",
                  bus.out_valid, bus.out_sel);
      end
      drain("reset");
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_rdy;
      do_reset();
      bus.in_valid = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         push_beat(3'(k % 8), 8'(8'h10 + (k % 8)));
      end
      for (int k = 0; k < 9; k++) begin
         exp_rdy = 8'h01 << (k % 8);
         #1;
         n_tests++;
         if (bus.in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL rr_ready[%0d]: got %h, required %h", k, bus.in_ready, exp_rdy);
         end
         step();
      end
      bus.in_valid = 8'h00;
      drain("rr");
   endtask

   task automatic test_wrap();
      do_reset();
      bus.in_valid = 8'h04;
      push_beat(3'd2, 8'h12);
      step();
      bus.in_valid = 8'h24;
      #1;
      n_tests++;
      if (bus.in_ready !== 8'h20) begin
         n_fail++;
         $display("FAIL wrap_first: got in_ready=%h, required 20", bus.in_ready);
      end
      push_beat(3'd5, 8'h15);
      step();
      bus.in_valid = 8'h04;
      #1;
      n_tests++;
      if (bus.in_ready !== 8'h04) begin
         n_fail++;
         $display("FAIL wrap_second: got in_ready=%h, required 04", bus.in_ready);
      end
      push_beat(3'd2, 8'h12);
      step();
      bus.in_valid = 8'h00;
      drain("wrap");
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.in_valid = 8'h03;
      push_beat(3'd0, 8'h10);
      step();
      bus.in_valid  = 8'h02;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_tests++;
         if (bus.in_ready !== 8'h00 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h10) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got in_ready=%h out_valid=%b out_data=%h, required 00/1/10",
                     k, bus.in_ready, bus.out_valid, bus.out_data);
         end
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      n_tests++;
      if (bus.in_ready !== 8'h02) begin
         n_fail++;
         $display("FAIL bp_release: got in_ready=%h, required 02", bus.in_ready);
      end
      push_beat(3'd1, 8'h11);
      step();
      bus.in_valid = 8'h00;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd1) begin
         n_fail++;
         $display("FAIL bp_reload: got out_valid=%b out_sel=%0d, required 1/1",
                  bus.out_valid, bus.out_sel);
      end
      drain("bp");
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b0;
      step();
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_loaded: got out_valid=%b, required 1", bus.out_valid);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 8'h00) begin
         n_fail++;
         $display("FAIL rstmid_async: got out_valid=%b in_ready=%h, required 0/00",
                  bus.out_valid, bus.in_ready);
      end
      @(posedge clk);
      #2;
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      n_tests++;
      if (bus.in_ready !== 8'h01) begin
         n_fail++;
         $display("FAIL rstmid_ptr: got in_ready=%h, required 01", bus.in_ready);
      end
      push_beat(3'd0, 8'h10);
      step();
      bus.in_valid = 8'h00;
      drain("rstmid");
   endtask

   task automatic test_lock();
      int         c1;
      int         c4;
      int         n4;
      int         cyc;
      logic [7:0] acc;
      do_reset();
      c1  = 0;
      c4  = 0;
      cyc = 0;
`ifdef MUX8_ARB_LOCK_EN
      n4 = 1;
      push_beat(3'd1, 8'hA1);
      push_beat(3'd1, 8'hA2);
      push_beat(3'd1, 8'hA3);
      push_beat(3'd4, 8'h40);
`else
      n4 = 2;
      push_beat(3'd1, 8'hA1);
      push_beat(3'd4, 8'h40);
      push_beat(3'd1, 8'hA2);
      push_beat(3'd4, 8'h41);
      push_beat(3'd1, 8'hA3);
`endif
      while ((c1 < 3 || c4 < n4) && cyc < 20) begin
         bus.in_valid[1]     = (c1 < 3);
         bus.in_valid[4]     = (c4 < n4);
         bus.in_data[8 +: 8] = 8'(8'hA1 + c1);
         bus.in_data[32 +: 8] = 8'(8'h40 + c4);
         bus.in_last[1]      = (c1 == 2);
         bus.in_last[4]      = 1'b1;
         #1;
         acc = bus.in_valid & bus.in_ready;
         step();
         if (acc[1]) c1++;
         if (acc[4]) c4++;
         cyc++;
      end
      bus.in_valid = 8'h00;
      bus.in_last  = 8'h00;
      n_tests++;
      if (c1 != 3 || c4 != n4) begin
         n_fail++;
         $display("FAIL lock_progress: got beats1=%0d beats4=%0d, required 3/%0d", c1, c4, n4);
      end
      drain("lock");
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      test_lock();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one WIDTH-bit datapath between eight requesters. It picks one valid requester per cycle and drives the 3-bit select of a generic Mux8 gate instance. The selected beat is captured into a one-entry output register with a valid/ready handshake. It sits in front of any single-consumer resource (bus port, shared ALU, link) that eight producers contend for.

## Interface
- WIDTH, 8: data width per requester, ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  8  per-requester beat valid; bit i = requester i.
- in_data  in  8*WIDTH  requester i data at [i*WIDTH +: WIDTH].
- in_last  in  8  per-requester last-beat flag; used only with lock enabled.
- in_ready  out  8  one-hot or zero; beat i transfers when in_valid[i] & in_ready[i].
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  3  index of requester that supplied out_data.
- out_ready  in  1  consumer accepts out beat when out_valid & out_ready.

## Operation
- can_load = !out_valid | out_ready.
- Round-robin pointer ptr[2:0] gives the highest-priority index. Search order is ptr, ptr+1, … ptr+7 mod 8. The first set in_valid bit is the grant g.
- in_ready[g] = can_load & |in_valid (combinational). All other in_ready bits are 0. If no request is present, in_ready = 0.
- Data path: a Mux8 instance selects in_data by g. Its output is registered on transfer.
- On transfer: out_data ← in_data[g], out_sel ← g, out_valid ← 1, ptr ← g+1 mod 8 (7 wraps to 0).
- If out_valid & out_ready and there is no transfer: out_valid ← 0. out_data and out_sel hold their values.
- Simultaneous output accept and new transfer: the register reloads, out_valid stays 1, and a beat is produced every cycle.
- Requesters keep in_valid and in_data stable until accepted. The arbiter is fair: with all eight requesting continuously, each gets exactly one beat in any 8 consecutive transfers.
- Reset (rst_n low, any time, asynchronous): out_valid 0, out_data 0, out_sel 0, ptr 0, lock state IDLE. in_ready is forced to 0 while rst_n is low. A beat held in the output register at reset is dropped.

## Timing
- Request to out_valid: 1 cycle. The beat is accepted at edge N and out_valid is high after edge N.
- Throughput: 1 beat/cycle while out_ready = 1.
- Backpressure: with out_valid = 1 and out_ready = 0, in_ready = 0 and out_* are stable.
- in_ready depends combinationally on in_valid, ptr, out_valid and out_ready. No other combinational input-to-output paths exist.

## Configuration
- MUX8_ARB_LOCK_EN defined: packet lock.
  - FSM with states IDLE and LOCKED(owner).
  - In IDLE, a transfer with in_last[g] = 0 moves the FSM to LOCKED with owner = g, and ptr is not updated.
  - In LOCKED, only the owner can be granted; other requesters are ignored even if valid. The grant goes to the owner only when in_valid[owner] = 1.
  - A transfer with in_last[owner] = 1 returns the FSM to IDLE and sets ptr ← owner+1.
  - An IDLE transfer with in_last = 1 behaves like the non-lock case.
- MUX8_ARB_LOCK_EN undefined: in_last is ignored, there is no lock state, and every beat is arbitrated independently.

## Test plan
- Reset: hold rst_n = 0 with in_valid = 8'hFF. Required: in_ready = 0, out_valid = 0, out_sel = 0. Release reset. Required: the first grant goes to requester 0 and out_sel = 0 one cycle later.
- All eight request continuously with out_ready = 1 and in_data[i] = i+8'h10. Required: out_sel sequence is 0,1,…,7,0 and out_data is 8'h10…8'h17, one per cycle.
- Requesters 2 and 5 valid, ptr = 3. Required: 5 is granted, then 2. The pointer wraps from 5+1 through 7 to 0.
- Backpressure: out_valid = 1 and out_ready = 0 for 4 cycles with requests pending. Required: in_ready = 0 and out_data is stable. Raise out_ready. Required: the next beat loads the same cycle and out_valid stays 1.
- Reset mid-stream: drop rst_n while out_valid = 1. Required: out_valid = 0 immediately (asynchronous) and ptr = 0 after release.
- With MUX8_ARB_LOCK_EN defined: requester 1 sends 3 beats (last on the 3rd) while requester 4 is valid throughout. Required: out_sel = 1,1,1 then 4. Without the macro: out_sel = 1,4,1,4,1.
